pipe_stage_reg: RTL and testbench

//  Parametrised inter-stage pipeline register (D/E, E/M, M/W) for the 5-stage MIPS core.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_slot.sv | 54 +++++
 rtl/pipe_stage_reg.sv | 177 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg
//  Shared constants and types for the inter-stage pipeline register.
//  PC_RESET_DEFAULT : pc shown on the output after reset (MIPS text base)
//  NOP_INSTR        : instruction word presented while the stage holds a bubble
//  stage_state_t    : occupancy of the main/skid slot pair
package pipe_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // (main valid, skid valid): EMPTY=(0,0), FULL=(1,0), SKIDFULL=(1,1)
    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FULL     = 2'd1,
        SKIDFULL = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot
//  One storage entry of the stage register: valid, instr, pc, we, payload.
//  Ports:
//   clk, reset             clock / synchronous active-high reset
//   load                   capture the d* fields and mark valid
//   clear                  drop the entry (bubble); pc is kept, clear beats load
//   dInstr/dPc/dWe/dPayload  entry to capture
//   valid/instr/pc/we/payload  stored entry
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 32,
    parameter int              PAYLOAD_W = 128,
    parameter logic [PC_W-1:0] PC_RESET  = PC_W'(PC_RESET_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [INSTR_W-1:0]   dInstr,
    input  logic [PC_W-1:0]      dPc,
    input  logic                 dWe,
    input  logic [PAYLOAD_W-1:0] dPayload,
    output logic                 valid,
    output logic [INSTR_W-1:0]   instr,
    output logic [PC_W-1:0]      pc,
    output logic                 we,
    output logic [PAYLOAD_W-1:0] payload
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid   <= 1'b0;
            instr   <= INSTR_W'(NOP_INSTR);
            pc      <= PC_RESET;
            we      <= 1'b0;
            payload <= '0;
        end else if (clear) begin
            // pc stays: a bubble still reports the address it replaced
            valid   <= 1'b0;
            instr   <= INSTR_W'(NOP_INSTR);
            we      <= 1'b0;
            payload <= '0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= dInstr;
            pc      <= dPc;
            we      <= dWe;
            payload <= dPayload;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//  Inter-stage pipeline register (D/E, E/M, M/W) with valid/ready handshake,
//  optional skid slot, flush-to-bubble and a saturating stall counter.
//  Ports:
//   clk, reset     clock / synchronous active-high reset (dominates everything)
//   flush          empty the stage next cycle, drop any same-cycle input
//   in_valid/in_ready, in_instr/in_pc/in_we/in_payload     upstream side
//   out_valid/out_ready, out_instr/out_pc/out_we/out_payload  downstream side
//   stall_cnt      cycles with out_valid && !out_ready (not counting flush cycles)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 32,
    parameter int              PAYLOAD_W = 128,
    parameter logic [PC_W-1:0] PC_RESET  = PC_W'(PC_RESET_DEFAULT),
    parameter int              SKID      = 1,
    parameter int              CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PC_W-1:0]      in_pc,
    input  logic                 in_we,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PC_W-1:0]      out_pc,
    output logic                 out_we,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic                 inFire, outFire;
    logic                 mainLoad, mainClear;
    logic [INSTR_W-1:0]   mainInstr;
    logic [PC_W-1:0]      mainPc;
    logic                 mainWe;
    logic [PAYLOAD_W-1:0] mainPayload;

    // A flushed cycle accepts nothing: the offered entry is dropped.
    assign inFire  = in_valid && in_ready && !flush;
    assign outFire = out_valid && out_ready;

    pipe_slot #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .PAYLOAD_W(PAYLOAD_W), .PC_RESET(PC_RESET)
    ) uMain (
        .clk      (clk),
        .reset    (reset),
        .load     (mainLoad),
        .clear    (mainClear),
        .dInstr   (mainInstr),
        .dPc      (mainPc),
        .dWe      (mainWe),
        .dPayload (mainPayload),
        .valid    (out_valid),
        .instr    (out_instr),
        .pc       (out_pc),
        .we       (out_we),
        .payload  (out_payload)
    );

    generate
        if (SKID != 0) begin : gSkid
            stage_state_t         state;
            logic                 inReadyR;
            logic                 skidLoad, skidClear;
            logic                 skidValid, skidWe;
            logic [INSTR_W-1:0]   skidInstr;
            logic [PC_W-1:0]      skidPc;
            logic [PAYLOAD_W-1:0] skidPayload;

            pipe_slot #(
                .PC_W(PC_W), .INSTR_W(INSTR_W), .PAYLOAD_W(PAYLOAD_W), .PC_RESET(PC_RESET)
            ) uSkid (
                .clk      (clk),
                .reset    (reset),
                .load     (skidLoad),
                .clear    (skidClear),
                .dInstr   (in_instr),
                .dPc      (in_pc),
                .dWe      (in_we),
                .dPayload (in_payload),
                .valid    (skidValid),
                .instr    (skidInstr),
                .pc       (skidPc),
                .we       (skidWe),
                .payload  (skidPayload)
            );

            // in_ready comes straight from a flop so upstream sees no
            // combinational path from out_ready.
            assign in_ready = inReadyR;

            // Skid holds the older entry, so it refills main before any new input.
            assign mainInstr   = skidValid ? skidInstr   : in_instr;
            assign mainPc      = skidValid ? skidPc      : in_pc;
            assign mainWe      = skidValid ? skidWe      : in_we;
            assign mainPayload = skidValid ? skidPayload : in_payload;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state    <= EMPTY;
                    inReadyR <= 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (inFire) state <= FULL;
                        end
                        FULL: begin
                            if (inFire && !outFire) begin
                                state    <= SKIDFULL;
                                inReadyR <= 1'b0;
                            end else if (!inFire && outFire) begin
                                state    <= EMPTY;
                            end
                        end
                        SKIDFULL: begin
                            if (outFire) begin
                                state    <= FULL;
                                inReadyR <= 1'b1;
                            end
                        end
                        default: begin
                            state    <= EMPTY;
                            inReadyR <= 1'b1;
                        end
                    endcase
                end
            end

            always_comb begin
                mainLoad  = 1'b0;
                mainClear = flush;
                skidLoad  = 1'b0;
                skidClear = flush;
                if (!flush) begin
                    case (state)
                        EMPTY: mainLoad = inFire;
                        FULL: begin
                            mainLoad  = inFire && outFire;
                            mainClear = outFire && !inFire;
                            skidLoad  = inFire && !outFire;
                        end
                        SKIDFULL: begin
                            mainLoad  = outFire;
                            skidClear = outFire;
                        end
                        default: ;
                    endcase
                end
            end
        end else begin : gNoSkid
            assign in_ready    = !out_valid || out_ready;
            assign mainInstr   = in_instr;
            assign mainPc      = in_pc;
            assign mainWe      = in_we;
            assign mainPayload = in_payload;
            assign mainLoad    = inFire;
            assign mainClear   = flush || (outFire && !inFire);
        end
    endgenerate

    // Saturating stall counter; flush cycles are not stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//  Directed bench: a per-cycle vector table against the SKID=1 build, then
//  hand sequences for the SKID=0 build, counter saturation (CNT_W=4),
//  reset mid-stall and flush clearing of the payload.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1, flush = 1'b0, inValid = 1'b0, outReady = 1'b0;
    logic [31:0]  inInstr = '0, inPc = '0;
    logic         inWe = 1'b0;
    logic [127:0] inPayload = '0;

    logic inReady, outValid, outWe;
    logic [31:0] outInstr, outPc;
    logic [127:0] outPayload;
    logic [15:0] stallCnt;

    logic inReady0, outValid0, outWe0;
    logic [31:0] outInstr0, outPc0;
    logic [127:0] outPayload0;
    logic [15:0] stallCnt0;

    logic inReadyC, outValidC, outWeC;
    logic [31:0] outInstrC, outPcC;
    logic [127:0] outPayloadC;
    logic [3:0] stallCntC;

    pipe_stage_reg #(.SKID(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady), .in_instr(inInstr), .in_pc(inPc),
        .in_we(inWe), .in_payload(inPayload),
        .out_valid(outValid), .out_ready(outReady), .out_instr(outInstr), .out_pc(outPc),
        .out_we(outWe), .out_payload(outPayload), .stall_cnt(stallCnt)
    );

    pipe_stage_reg #(.SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReady0), .in_instr(inInstr), .in_pc(inPc),
        .in_we(inWe), .in_payload(inPayload),
        .out_valid(outValid0), .out_ready(outReady), .out_instr(outInstr0), .out_pc(outPc0),
        .out_we(outWe0), .out_payload(outPayload0), .stall_cnt(stallCnt0)
    );

    pipe_stage_reg #(.SKID(1), .CNT_W(4)) dutC (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyC), .in_instr(inInstr), .in_pc(inPc),
        .in_we(inWe), .in_payload(inPayload),
        .out_valid(outValidC), .out_ready(outReady), .out_instr(outInstrC), .out_pc(outPcC),
        .out_we(outWeC), .out_payload(outPayloadC), .stall_cnt(stallCntC)
    );

    // Entry fields are derived from pc so an entry is identified by its pc alone.
    function automatic logic [31:0] fInstr(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction
    function automatic logic [127:0] fPay(input logic [31:0] pc);
        return {pc, ~pc, pc + 32'd1, 32'h5A5A_5A5A};
    endfunction

    typedef struct {
        logic        rst, fl, iv;
        logic [31:0] pc;
        logic        ordy, chk;
        logic        ir, ov;
        logic [31:0] opc;
        logic [15:0] sc;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, iv, input logic [31:0] pc,
                                input logic ordy, chk, ir, ov,
                                input logic [31:0] opc, input logic [15:0] sc);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy; v.chk = chk;
        v.ir = ir; v.ov = ov; v.opc = opc; v.sc = sc;
        return v;
    endfunction

    int nVec = 0;
    int nBad = 0;

    task automatic check(input string name, input logic ok, input string detail);
        nVec++;
        if (ok !== 1'b1) begin
            nBad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic rst, fl, iv, input logic [31:0] pc, input logic ordy);
        @(negedge clk);
        reset = rst; flush = fl; inValid = iv; outReady = ordy;
        inPc = pc; inInstr = fInstr(pc); inWe = pc[2]; inPayload = fPay(pc);
        #1;
    endtask

    vec_t tbl[26];

    initial begin
        logic        mv, expIr, ok;
        logic [31:0] mpc, pcNext, expInstr;
        logic        expWe;
        logic [7:0]  ivPat, rdyPat;

        //            rst fl iv pc         ordy chk ir ov opc        sc
        tbl[0]  = mk(1, 0, 0, 32'h0,    0,   0,  0, 0, 32'h0,    0);
        tbl[1]  = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3000, 0); // reset state
        tbl[2]  = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3000, 0);
        tbl[3]  = mk(0, 0, 1, 32'h3000, 1,   1,  1, 0, 32'h3000, 0); // stream
        tbl[4]  = mk(0, 0, 1, 32'h3004, 1,   1,  1, 1, 32'h3000, 0);
        tbl[5]  = mk(0, 0, 1, 32'h3008, 1,   1,  1, 1, 32'h3004, 0);
        tbl[6]  = mk(0, 0, 1, 32'h300C, 1,   1,  1, 1, 32'h3008, 0);
        tbl[7]  = mk(0, 0, 0, 32'h0,    1,   1,  1, 1, 32'h300C, 0);
        tbl[8]  = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h300C, 0);
        tbl[9]  = mk(0, 0, 1, 32'h3000, 0,   1,  1, 0, 32'h300C, 0); // stall + skid
        tbl[10] = mk(0, 0, 1, 32'h3004, 0,   1,  1, 1, 32'h3000, 0);
        tbl[11] = mk(0, 0, 1, 32'h3008, 0,   1,  0, 1, 32'h3000, 1);
        tbl[12] = mk(0, 0, 1, 32'h3008, 0,   1,  0, 1, 32'h3000, 2);
        tbl[13] = mk(0, 0, 1, 32'h3008, 1,   1,  0, 1, 32'h3000, 3);
        tbl[14] = mk(0, 0, 1, 32'h3008, 1,   1,  1, 1, 32'h3004, 3);
        tbl[15] = mk(0, 0, 0, 32'h0,    1,   1,  1, 1, 32'h3008, 3);
        tbl[16] = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3008, 3);
        tbl[17] = mk(0, 0, 1, 32'h3010, 0,   1,  1, 0, 32'h3008, 3); // flush in SKIDFULL
        tbl[18] = mk(0, 0, 1, 32'h3014, 0,   1,  1, 1, 32'h3010, 3);
        tbl[19] = mk(0, 1, 1, 32'h3018, 0,   1,  0, 1, 32'h3010, 4);
        tbl[20] = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3010, 4);
        tbl[21] = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3010, 4);
        tbl[22] = mk(0, 0, 1, 32'h3020, 0,   1,  1, 0, 32'h3010, 4); // reset beats flush
        tbl[23] = mk(0, 0, 1, 32'h3024, 0,   1,  1, 1, 32'h3020, 4);
        tbl[24] = mk(1, 1, 1, 32'h3028, 0,   1,  0, 1, 32'h3020, 5);
        tbl[25] = mk(0, 0, 0, 32'h0,    1,   1,  1, 0, 32'h3000, 0);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].pc, tbl[i].ordy);
            if (tbl[i].chk) begin
                expInstr = tbl[i].ov ? fInstr(tbl[i].opc) : 32'h0;
                expWe    = tbl[i].ov ? tbl[i].opc[2] : 1'b0;
                ok = (inReady === tbl[i].ir) && (outValid === tbl[i].ov) &&
                     (outPc === tbl[i].opc) && (stallCnt === tbl[i].sc) &&
                     (outInstr === expInstr) && (outWe === expWe) &&
                     (!tbl[i].ov || outPayload === fPay(tbl[i].opc));
                check($sformatf("vec%0d", i), ok,
                      $sformatf("got ir=%b ov=%b pc=%h instr=%h we=%b sc=%0d, want ir=%b ov=%b pc=%h instr=%h we=%b sc=%0d",
                                inReady, outValid, outPc, outInstr, outWe, stallCnt,
                                tbl[i].ir, tbl[i].ov, tbl[i].opc, expInstr, expWe, tbl[i].sc));
            end
        end

        // SKID=0: in_ready = !out_valid || out_ready in the same cycle.
        step(1, 0, 0, 32'h0, 1);
        mv = 1'b0; mpc = 32'h3000; pcNext = 32'h3100;
        ivPat = 8'b1011_0111; rdyPat = 8'b0110_1101;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, ivPat[i], pcNext, rdyPat[i]);
            expIr = !mv || rdyPat[i];
            ok = (inReady0 === expIr) && (outValid0 === mv) && (outPc0 === mpc) &&
                 (outInstr0 === (mv ? fInstr(mpc) : 32'h0));
            check($sformatf("skid0_%0d", i), ok,
                  $sformatf("got ir=%b ov=%b pc=%h instr=%h, want ir=%b ov=%b pc=%h",
                            inReady0, outValid0, outPc0, outInstr0, expIr, mv, mpc));
            if (ivPat[i] && expIr) begin
                mv = 1'b1; mpc = pcNext; pcNext = pcNext + 32'd4;
            end else if (mv && rdyPat[i]) begin
                mv = 1'b0;
            end
        end

        // Flush clears the whole bubble, keeps pc; flushed entries never surface.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h3200, 0);
        step(0, 0, 1, 32'h3204, 0);
        step(0, 1, 1, 32'h3208, 0);
        step(0, 0, 0, 32'h0, 1);
        check("flush_bubble",
              outValid === 1'b0 && outInstr === 32'h0 && outWe === 1'b0 &&
              outPayload === 128'h0 && outPc === 32'h3200 && inReady === 1'b1 && stallCnt === 16'd1,
              $sformatf("got ov=%b instr=%h we=%b pay=%h pc=%h ir=%b sc=%0d, want 0/0/0/0/3200/1/1",
                        outValid, outInstr, outWe, outPayload, outPc, inReady, stallCnt));
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        check("flush_no_ghost", outValid === 1'b0 && outPc === 32'h3200,
              $sformatf("got ov=%b pc=%h, want ov=0 pc=3200", outValid, outPc));

        // Counter saturation with CNT_W=4, then reset in the middle of the stall.
        step(1, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h3300, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 32'h0, 0);
            if (i == 15)
                check("sat_reach", stallCntC === 4'hF,
                      $sformatf("got %h, want f", stallCntC));
        end
        check("sat_stick", stallCntC === 4'hF && stallCnt === 16'd19,
              $sformatf("got c4=%h c16=%0d, want f and 19", stallCntC, stallCnt));
        step(1, 0, 1, 32'h3304, 0);
        step(0, 0, 0, 32'h0, 0);
        check("reset_mid_stall",
              outValidC === 1'b0 && outPcC === 32'h3000 && outInstrC === 32'h0 &&
              outWeC === 1'b0 && outPayloadC === 128'h0 && inReadyC === 1'b1 && stallCntC === 4'h0,
              $sformatf("got ov=%b pc=%h instr=%h we=%b ir=%b sc=%h, want 0/3000/0/0/1/0",
                        outValidC, outPcC, outInstrC, outWeC, inReadyC, stallCntC));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
